// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-facing signal bundle for sync_fifo_param.
// The master side drives requests and data; the slave side is the FIFO itself.
interface sync_fifo_param_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                  clr;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;

  modport master (
    output clr, data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  clr, data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds, synchronous
// flush and optional first-word-fall-through read data.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int FWFT       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_ack_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [FIFO_WIDTH-1:0] dout;

  // Explicit wrap so depths that are not a power of two never index past the end.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count_q;
    if (wr_acc && !rd_acc)
      count_nxt = count_q + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count_q - CW'(1);
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      count_q     <= count_nxt;
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en & full;
      underflow_q <= bus.rd_en & empty;
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is always visible; contents are meaningless while empty.
      assign dout = mem[rd_ptr];
    end else begin : g_registered
      logic [FIFO_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          dout_q <= '0;
        else if (rd_acc)
          dout_q <= mem[rd_ptr];
      end

      assign dout = dout_q;
    end
  endgenerate

  assign bus.data_out    = dout;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count_q >= AF_LEVEL) & ~full;
  assign bus.almostempty = ~empty & (count_q <= AE_LEVEL);
  assign bus.count       = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: 8-deep registered, 5-deep wrap and
// 8-deep FWFT instances sharing one clock and reset.
module tb_sync_fifo_param;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b0 ();
  sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b1 ();
  sync_fifo_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b2 ();

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0))
    u_base (.clk(clk), .rst_n(rst_n), .bus(b0));
  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(b1));
  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just past it; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state for the wrap stream
  int          nw, nr, mc, t;
  logic        w, r, wa, ra;
  logic [15:0] exp_d;
  logic [15:0] q [$];

  initial begin
    rst_n = 1'b0;
    b0.clr = 0; b0.wr_en = 0; b0.rd_en = 0; b0.data_in = '0;
    b1.clr = 0; b1.wr_en = 0; b1.rd_en = 0; b1.data_in = '0;
    b2.clr = 0; b2.wr_en = 0; b2.rd_en = 0; b2.data_in = '0;
    #3;
    check("rst_count",  b0.count, 0);
    check("rst_empty",  b0.empty, 1);
    check("rst_full",   b0.full, 0);
    check("rst_dout",   b0.data_out, 0);
    check("rst_wr_ack", b0.wr_ack, 0);
    check("rst_af",     b0.almostfull, 0);
    check("rst_ae",     b0.almostempty, 0);
    #9 rst_n = 1'b1;
    step();

    // Fill 0x0001..0x0008
    for (int i = 1; i <= 8; i++) begin
      b0.wr_en = 1; b0.data_in = 16'(i);
      step();
      check("fill_ack",   b0.wr_ack, 1);
      check("fill_count", b0.count, i);
      check("fill_af",    b0.almostfull, (i == 7) ? 1 : 0);
      check("fill_full",  b0.full, (i == 8) ? 1 : 0);
      check("fill_ae",    b0.almostempty, (i == 1) ? 1 : 0);
    end

    // Write while full
    b0.data_in = 16'h0099;
    step();
    check("ovf_flag",  b0.overflow, 1);
    check("ovf_ack",   b0.wr_ack, 0);
    check("ovf_count", b0.count, 8);
    b0.wr_en = 0;
    step();
    check("ovf_pulse", b0.overflow, 0);

    // Read+write at full: only the read is taken
    b0.wr_en = 1; b0.rd_en = 1; b0.data_in = 16'h0077;
    step();
    check("sim_full_ovf",   b0.overflow, 1);
    check("sim_full_count", b0.count, 7);
    check("sim_full_dout",  b0.data_out, 16'h0001);
    b0.wr_en = 0;
    for (int i = 2; i <= 8; i++) begin
      step();
      check("drain_dout",  b0.data_out, i);
      check("drain_count", b0.count, 8 - i);
      check("drain_ae",    b0.almostempty, (i == 7) ? 1 : 0);
      check("drain_empty", b0.empty, (i == 8) ? 1 : 0);
    end

    // Read while empty
    step();
    check("udf_flag", b0.underflow, 1);
    check("udf_dout", b0.data_out, 16'h0008);
    check("udf_count", b0.count, 0);
    b0.rd_en = 0;
    step();
    check("udf_pulse", b0.underflow, 0);

    // Read+write at count 3
    b0.wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      b0.data_in = 16'h0010 + 16'(i);
      step();
    end
    b0.rd_en = 1;
    for (int i = 0; i < 2; i++) begin
      b0.data_in = 16'h0013 + 16'(i);
      step();
      check("sim3_count", b0.count, 3);
      check("sim3_dout",  b0.data_out, 16'h0010 + 16'(i));
    end
    b0.wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("sim3_drain", b0.data_out, 16'h0012 + 16'(i));
    end
    b0.rd_en = 0;
    check("sim3_empty", b0.empty, 1);

    // Flush with count 5 and a concurrent write
    b0.wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      b0.data_in = 16'h0020 + 16'(i);
      step();
    end
    check("clr_pre_count", b0.count, 5);
    b0.clr = 1; b0.data_in = 16'h0055;
    step();
    check("clr_count", b0.count, 0);
    check("clr_empty", b0.empty, 1);
    check("clr_ack",   b0.wr_ack, 0);
    check("clr_dout",  b0.data_out, 16'h0014);
    b0.clr = 0; b0.data_in = 16'h0066;
    step();
    b0.wr_en = 0; b0.rd_en = 1;
    step();
    b0.rd_en = 0;
    check("clr_after_dout", b0.data_out, 16'h0066);

    // Depth-5 stream: 20 words with interleaved reads across pointer wrap
    nw = 0; nr = 0; mc = 0; t = 0;
    while ((nw < 20 || mc > 0) && t < 200) begin
      w = (nw < 20) && (t < 5 || (t % 3) != 0);
      r = (t >= 5) && ((t % 2) == 0 || nw >= 20);
      b1.wr_en = w; b1.rd_en = r; b1.data_in = 16'(16'h0100 + nw);
      wa = w && (mc < 5);
      ra = r && (mc > 0);
      if (ra) exp_d = q.pop_front();
      if (wa) begin q.push_back(16'(16'h0100 + nw)); nw++; end
      mc = mc + int'(wa) - int'(ra);
      step();
      if (ra) begin
        check("wrap_data", b1.data_out, exp_d);
        nr++;
      end
      check("wrap_count", b1.count, mc);
      check("wrap_af",    b1.almostfull, (mc >= 3 && mc <= 4) ? 1 : 0);
      check("wrap_ae",    b1.almostempty, (mc >= 1 && mc <= 2) ? 1 : 0);
      check("wrap_full",  b1.full, (mc == 5) ? 1 : 0);
      t++;
    end
    b1.wr_en = 0; b1.rd_en = 0;
    check("wrap_bound", (t < 200) ? 1 : 0, 1);
    check("wrap_reads", nr, 20);

    // FWFT: head visible without a read
    b2.wr_en = 1; b2.data_in = 16'hABCD;
    step();
    b2.wr_en = 0;
    check("fwft_dout",  b2.data_out, 16'hABCD);
    check("fwft_empty", b2.empty, 0);
    step();
    check("fwft_hold", b2.data_out, 16'hABCD);
    b2.rd_en = 1;
    step();
    b2.rd_en = 0;
    check("fwft_pop_empty", b2.empty, 1);
    b2.wr_en = 1; b2.data_in = 16'h1111;
    step();
    b2.data_in = 16'h2222;
    step();
    b2.wr_en = 0;
    check("fwft_head1", b2.data_out, 16'h1111);
    b2.rd_en = 1;
    step();
    b2.rd_en = 0;
    check("fwft_head2", b2.data_out, 16'h2222);

    // Asynchronous reset mid-cycle with count 5
    b0.wr_en = 1;
    for (int i = 0; i < 5; i++) begin
      b0.data_in = 16'h0030 + 16'(i);
      step();
    end
    b0.wr_en = 0; b0.rd_en = 1;
    step();
    b0.rd_en = 0;
    b0.wr_en = 1; b0.data_in = 16'h0035;
    step();
    b0.wr_en = 0;
    check("arst_pre_count", b0.count, 5);
    check("arst_pre_ack",   b0.wr_ack, 1);
    check("arst_pre_dout",  b0.data_out, 16'h0030);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", b0.count, 0);
    check("arst_empty", b0.empty, 1);
    check("arst_full",  b0.full, 0);
    check("arst_dout",  b0.data_out, 0);
    check("arst_ack",   b0.wr_ack, 0);
    check("arst_af",    b0.almostfull, 0);
    check("arst_ae",    b0.almostempty, 0);
    #1 rst_n = 1'b1;
    step();
    b0.wr_en = 1; b0.data_in = 16'hBEEF;
    step();
    b0.wr_en = 0; b0.rd_en = 1;
    step();
    b0.rd_en = 0;
    check("arst_first_word", b0.data_out, 16'hBEEF);
    check("arst_after_empty", b0.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the next generation of the team's 16-bit/8-deep FIFO. It adds configurable depth (power of two not required), width, almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain. It keeps the existing status semantics: wr_ack, overflow and underflow are registered; the full/empty family is combinational from occupancy.

## Interface
- FIFO_WIDTH, 16, data width in bits (≥1)
- FIFO_DEPTH, 8, number of entries (≥2; any integer)
- AF_MARGIN, 1, almostfull asserts when count ≥ FIFO_DEPTH−AF_MARGIN (1 ≤ AF_MARGIN < FIFO_DEPTH)
- AE_MARGIN, 1, almostempty asserts when count ≤ AE_MARGIN (1 ≤ AE_MARGIN < FIFO_DEPTH)
- FWFT, 0, 0 = registered read data; 1 = head entry visible on data_out without a read
- CW, derived = $clog2(FIFO_DEPTH+1), count width

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- clr  input  1  synchronous flush
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request
- data_out  output  FIFO_WIDTH  read data
- wr_ack  output  1  registered; the previous cycle's write was accepted
- overflow  output  1  registered; the previous cycle's write was rejected
- underflow  output  1  registered; the previous cycle's read was rejected
- full  output  1  count == FIFO_DEPTH
- empty  output  1  count == 0
- almostfull  output  1  count ≥ FIFO_DEPTH−AF_MARGIN and not full
- almostempty  output  1  1 ≤ count ≤ AE_MARGIN
- count  output  CW  current occupancy

## Operation
- **State:** write pointer, read pointer and count registers. Both pointers wrap from FIFO_DEPTH−1 to 0, which must be explicit for non-power-of-2 depths.
- **Write acceptance:** wr_acc = wr_en & !full & !clr. Store data_in at wr_ptr and advance wr_ptr.
- **Read acceptance:** rd_acc = rd_en & !empty & !clr. Advance rd_ptr.
- **Acceptance basis:** both decisions use the pre-edge full/empty. When full, a simultaneous rd+wr accepts only the read. When empty, it accepts only the write.
- **Count update:** count += wr_acc − rd_acc. When both are accepted, count is unchanged.
- **Status registers:**
  - wr_ack ← wr_acc
  - overflow ← wr_en & full & !clr
  - underflow ← rd_en & empty & !clr
- **FWFT=0:** data_out is a register that loads mem[rd_ptr] on rd_acc and otherwise holds.
- **FWFT=1:** data_out = mem[rd_ptr] combinationally. It is valid whenever !empty and is don't-care when empty. rd_acc pops the entry.
- **clr:**
  - Pointers and count go to 0, and wr_ack/overflow/underflow go to 0.
  - A simultaneous wr_en or rd_en is ignored.
  - data_out holds its value in FWFT=0.
  - Memory contents are not cleared.
- **Memory:** the array is not reset.

## Timing
- **Reset (rst_n low, asynchronous):**
  - count=0, pointers=0.
  - data_out=0 in FWFT=0.
  - wr_ack=0, overflow=0, underflow=0.
  - empty=1, full=0, almostfull=0, almostempty=0.
- **Reset mid-operation:** all entries are lost. The first accepted write after deassertion lands in entry 0.
- **Deassertion:** rst_n is released asynchronously. The first active edge is the first clk edge at which rst_n is sampled high.
- **Flags and count:** update in the same cycle as the edge that changes count, i.e. zero cycles after that edge.
- **wr_ack/overflow/underflow:** valid one cycle after the request edge and high for exactly one cycle per request.
- **Write-to-read latency:**
  - FWFT=0: a write at edge N makes empty low after edge N. rd_en sampled at edge N+1 presents the data on data_out after edge N+1.
  - FWFT=1: the data is on data_out after edge N.
- **Burst throughput:** one write and one read per cycle sustained.

## Test plan
- **Fill/drain:** FIFO_WIDTH=16, FIFO_DEPTH=8. Write 0x0001..0x0008, then read 8.
  - While filling: wr_ack=1 on each of the 8 cycles; almostfull=1 at count=7; full=1 at count=8.
  - While draining: data_out returns 0x0001..0x0008 in order; almostempty=1 at count=1; empty=1 at the end.
- **Overflow/underflow:**
  - wr_en while count=8: overflow=1 for one cycle, wr_ack=0, count stays 8.
  - rd_en while count=0: underflow=1 for one cycle, data_out unchanged.
- **Simultaneous rd+wr:**
  - At full: the read is accepted, the write is rejected (overflow=1), count 8→7.
  - At count=3: count stays 3 and FIFO order is preserved.
- **Non-power-of-2 wrap:** FIFO_DEPTH=5, AF_MARGIN=2, AE_MARGIN=2. Stream 20 words with interleaved reads.
  - Order is preserved across pointer wrap 4→0.
  - almostfull=1 at count 3..4; almostempty=1 at count 1..2.
- **FWFT=1:** write 0xABCD into an empty FIFO.
  - data_out=0xABCD on the next cycle with no rd_en.
  - rd_en then gives empty=1.
- **clr and async reset:**
  - With count=5, assert clr together with wr_en: next cycle count=0, empty=1, wr_ack=0.
  - Separately, with count=5, pulse rst_n low mid-cycle: all outputs go to their reset values immediately, without waiting for clk.
